// File: rtl/drum_scene_gen.sv
// Drum-kit scene generator: circular pads that flash on hits,
// plus a BCD stopwatch overlay. Output colour is registered.
module drum_scene_gen #(
  parameter int NUM_PADS = 4,
  parameter logic [NUM_PADS*10-1:0] PAD_X =
    {10'd520, 10'd430, 10'd320, 10'd240},
  parameter logic [NUM_PADS*10-1:0] PAD_Y =
    {10'd300, 10'd180, 10'd200, 10'd300},
  parameter logic [NUM_PADS*10-1:0] PAD_R =
    {10'd40, 10'd28, 10'd30, 10'd45},
  parameter logic [NUM_PADS*6-1:0] PAD_IDLE_RGB =
    {6'h3C, 6'h03, 6'h0C, 6'h30},
  parameter logic [NUM_PADS*6-1:0] PAD_FLASH_RGB =
    {6'h3E, 6'h2B, 6'h2E, 6'h3A},
  parameter int FLASH_FRAMES    = 24,
  parameter int BUMP            = 4,
  parameter int DEBOUNCE_FRAMES = 10,
  parameter int FRAMES_PER_SEC  = 60,
  parameter int TIMER_X         = 10,
  parameter int TIMER_Y         = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [9:0]          row,
  input  logic [9:0]          col,
  input  logic                visible,
  input  logic [NUM_PADS-1:0] hit,
  input  logic                start_btn,
  input  logic                clear_btn,
  output logic [5:0]          rgb,
  output logic [15:0]         seconds_bcd,
  output logic                running
);

  localparam int DW =
    FRAMES_PER_SEC > 1 ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(FRAMES_PER_SEC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE
  } state_e;

  state_e state_q, state_d;
  logic [NUM_PADS-1:0]      pend_q, pend_d;
  logic [NUM_PADS-1:0][5:0] flash_q, flash_d;
  logic [1:0]  st_sync_q, cl_sync_q;
  logic        st_prev_q, st_prev_d;
  logic        cl_prev_q, cl_prev_d;
  logic [7:0]  lock_q, lock_d;
  logic [DW-1:0] div_q, div_d;
  logic [15:0] sec_q, sec_d;
  logic [5:0]  rgb_q, rgb_d;

  logic frame_tick, st_acc, cl_acc;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    if (v != 16'h9999) begin
      for (int k = 0; k < 4; k++) begin
        if (c) begin
          if (r[4*k +: 4] == 4'd9) begin
            r[4*k +: 4] = 4'd0;
          end else begin
            r[4*k +: 4] = r[4*k +: 4] + 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [9:0] absdiff(input logic [9:0] a,
                                         input logic [9:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  function automatic logic covers(input logic [9:0] c,
                                  input logic [9:0] r,
                                  input logic [9:0] px,
                                  input logic [9:0] py,
                                  input logic [9:0] pr);
    logic [20:0] dx, dy, rr;
    dx = 21'(absdiff(c, px));
    dy = 21'(absdiff(r, py));
    rr = 21'(pr);
    return (dx * dx + dy * dy) <= rr * rr;
  endfunction

  // 5x7 glyphs, top row in the MSBs, leftmost pixel is bit 4.
  function automatic logic [4:0] font_row(input logic [3:0] code,
                                          input logic [2:0] r);
    logic [34:0] g;
    unique case (code)
      4'd0: g = {5'h0E,5'h11,5'h13,5'h15,5'h19,5'h11,5'h0E};
      4'd1: g = {5'h04,5'h0C,5'h04,5'h04,5'h04,5'h04,5'h0E};
      4'd2: g = {5'h0E,5'h11,5'h01,5'h02,5'h04,5'h08,5'h1F};
      4'd3: g = {5'h1F,5'h02,5'h04,5'h02,5'h01,5'h11,5'h0E};
      4'd4: g = {5'h02,5'h06,5'h0A,5'h12,5'h1F,5'h02,5'h02};
      4'd5: g = {5'h1F,5'h10,5'h1E,5'h01,5'h01,5'h11,5'h0E};
      4'd6: g = {5'h06,5'h08,5'h10,5'h1E,5'h11,5'h11,5'h0E};
      4'd7: g = {5'h1F,5'h01,5'h02,5'h04,5'h08,5'h08,5'h08};
      4'd8: g = {5'h0E,5'h11,5'h11,5'h0E,5'h11,5'h11,5'h0E};
      4'd9: g = {5'h0E,5'h11,5'h11,5'h0F,5'h01,5'h02,5'h0C};
      default: g = {5'h1F,5'h04,5'h04,5'h04,5'h04,5'h04,5'h04};
    endcase
    return g[6'd34 - 6'(r) * 6'd5 -: 5];
  endfunction

  assign frame_tick = (row == 10'd0) && (col == 10'd0);
  assign st_acc = frame_tick && st_sync_q[1] && !st_prev_q &&
                  (lock_q == 8'd0);
  assign cl_acc = frame_tick && cl_sync_q[1] && !cl_prev_q &&
                  (lock_q == 8'd0);

  always_comb begin
    pend_d    = pend_q | hit;
    flash_d   = flash_q;
    st_prev_d = st_prev_q;
    cl_prev_d = cl_prev_q;
    lock_d    = lock_q;
    if (frame_tick) begin
      pend_d = '0;
      for (int i = 0; i < NUM_PADS; i++) begin
        if (pend_q[i] || hit[i]) begin
          flash_d[i] = 6'(FLASH_FRAMES);
        end else if (flash_q[i] != 6'd0) begin
          flash_d[i] = flash_q[i] - 6'd1;
        end
      end
      st_prev_d = st_sync_q[1];
      cl_prev_d = cl_sync_q[1];
      if (st_acc || cl_acc) begin
        lock_d = 8'(DEBOUNCE_FRAMES);
      end else if (lock_q != 8'd0) begin
        lock_d = lock_q - 8'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    sec_d   = sec_q;
    if (cl_acc) begin
      state_d = S_IDLE;
      div_d   = '0;
      sec_d   = 16'h0000;
    end else if (st_acc) begin
      state_d = (state_q == S_RUN) ? S_PAUSE : S_RUN;
      div_d   = '0;
    end else if (frame_tick && state_q == S_RUN) begin
      if (div_q == DIV_MAX) begin
        div_d = '0;
        sec_d = bcd_inc(sec_q);
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  logic [9:0] tx, ty;
  logic [4:0] gsel, gx;
  logic [3:0] code;
  logic       in_t, blank;

  always_comb begin
    tx    = col - 10'(TIMER_X);
    ty    = row - 10'(TIMER_Y);
    in_t  = (col >= 10'(TIMER_X)) && (col < 10'(TIMER_X + 30)) &&
            (row >= 10'(TIMER_Y)) && (row < 10'(TIMER_Y + 7));
    gsel  = tx[4:0] / 5'd6;
    gx    = tx[4:0] - gsel * 5'd6;
    code  = 4'd10;
    blank = 1'b0;
    unique case (gsel)
      5'd1: begin
        code  = sec_q[15:12];
        blank = sec_q[15:12] == 4'd0;
      end
      5'd2: begin
        code  = sec_q[11:8];
        blank = sec_q[15:8] == 8'd0;
      end
      5'd3: begin
        code  = sec_q[7:4];
        blank = sec_q[15:4] == 12'd0;
      end
      5'd4: code = sec_q[3:0];
      default: code = 4'd10;
    endcase

    rgb_d = 6'h3F;
    // Walk downwards so the lowest-index pad is written last.
    for (int i = NUM_PADS - 1; i >= 0; i--) begin
      if (covers(col, row, PAD_X[i*10 +: 10],
                 PAD_Y[i*10 +: 10] -
                   ((flash_q[i] != 6'd0) ? 10'(BUMP) : 10'd0),
                 PAD_R[i*10 +: 10])) begin
        rgb_d = (flash_q[i] != 6'd0) ? PAD_FLASH_RGB[i*6 +: 6]
                                     : PAD_IDLE_RGB[i*6 +: 6];
      end
    end
    if (in_t && gx < 5'd5 && !blank &&
        font_row(code, ty[2:0])[3'd4 - gx[2:0]]) begin
      rgb_d = 6'h00;
    end
    if (!visible) begin
      rgb_d = 6'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pend_q    <= '0;
      flash_q   <= '0;
      st_sync_q <= 2'b00;
      cl_sync_q <= 2'b00;
      st_prev_q <= 1'b0;
      cl_prev_q <= 1'b0;
      lock_q    <= 8'd0;
      div_q     <= '0;
      sec_q     <= 16'h0000;
      rgb_q     <= 6'h00;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      flash_q   <= flash_d;
      st_sync_q <= {st_sync_q[0], start_btn};
      cl_sync_q <= {cl_sync_q[0], clear_btn};
      st_prev_q <= st_prev_d;
      cl_prev_q <= cl_prev_d;
      lock_q    <= lock_d;
      div_q     <= div_d;
      sec_q     <= sec_d;
      rgb_q     <= rgb_d;
    end
  end

  assign rgb         = rgb_q;
  assign seconds_bcd = sec_q;
  assign running     = (state_q == S_RUN);

endmodule

// File: tb/tb_drum_scene_gen.sv
// Directed bench for drum_scene_gen: pad rendering, flash timing,
// stopwatch control and saturation, reset behaviour.
module tb_drum_scene_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  row, col;
  logic        visible;
  logic [3:0]  hit;
  logic        start_btn, clear_btn, start2, clear2;
  logic [5:0]  rgb, rgb2;
  logic [15:0] sec, sec2;
  logic        running, running2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  drum_scene_gen dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .visible(visible), .hit(hit),
    .start_btn(start_btn), .clear_btn(clear_btn),
    .rgb(rgb), .seconds_bcd(sec), .running(running)
  );

  // Second copy counts one second per frame to reach 9999 quickly.
  drum_scene_gen #(.FRAMES_PER_SEC(1)) dut2 (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .visible(visible), .hit(hit),
    .start_btn(start2), .clear_btn(clear2),
    .rgb(rgb2), .seconds_bcd(sec2), .running(running2)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    row = 10'd0;
    col = 10'd0;
    visible = 1'b0;
    @(posedge clk); #1;
    col = 10'd1;
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pix(input string tag, input logic [9:0] r,
                     input logic [9:0] c, input logic v,
                     input logic [5:0] exp);
    row = r;
    col = c;
    visible = v;
    @(posedge clk); #1;
    chk(tag, {10'd0, rgb}, {10'd0, exp});
  endtask

  initial begin
    rst = 1'b1;
    row = 10'd5;
    col = 10'd5;
    visible = 1'b0;
    hit = 4'd0;
    start_btn = 1'b0;
    clear_btn = 1'b0;
    start2 = 1'b0;
    clear2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", {10'd0, rgb}, 16'h0000);
    chk("rst_sec", sec, 16'h0000);
    chk("rst_run", {15'd0, running}, 16'h0000);
    rst = 1'b0;

    pix("pad1_idle", 10'd200, 10'd320, 1'b1, 6'h0C);
    pix("corner", 10'd479, 10'd0, 1'b1, 6'h3F);
    pix("invis", 10'd200, 10'd320, 1'b0, 6'h00);
    pix("T_top", 10'd10, 10'd12, 1'b1, 6'h00);
    pix("T_stem", 10'd12, 10'd12, 1'b1, 6'h00);
    pix("T_side", 10'd12, 10'd10, 1'b1, 6'h3F);
    pix("gap", 10'd10, 10'd15, 1'b1, 6'h3F);
    pix("blank_k", 10'd10, 10'd18, 1'b1, 6'h3F);
    pix("blank_t", 10'd10, 10'd30, 1'b1, 6'h3F);
    pix("ones0", 10'd10, 10'd36, 1'b1, 6'h00);
    pix("p1_top_idle", 10'd166, 10'd320, 1'b1, 6'h3F);
    pix("p1_edge_idle", 10'd170, 10'd320, 1'b1, 6'h0C);

    row = 10'd100;
    col = 10'd100;
    hit = 4'b0010;
    @(posedge clk); #1;
    hit = 4'd0;
    pix("midframe_bot", 10'd230, 10'd320, 1'b1, 6'h0C);
    pix("midframe_top", 10'd166, 10'd320, 1'b1, 6'h3F);
    tick();
    pix("flash_top", 10'd166, 10'd320, 1'b1, 6'h2E);
    pix("flash_ctr", 10'd196, 10'd320, 1'b1, 6'h2E);
    pix("flash_bot", 10'd230, 10'd320, 1'b1, 6'h3F);
    ticks(23);
    pix("flash_last", 10'd196, 10'd320, 1'b1, 6'h2E);
    tick();
    pix("flash_done", 10'd196, 10'd320, 1'b1, 6'h0C);
    pix("done_bot", 10'd230, 10'd320, 1'b1, 6'h0C);

    start_btn = 1'b1;
    ticks(3);
    chk("start_run", {15'd0, running}, 16'h0001);
    start_btn = 1'b0;
    ticks(2);
    start_btn = 1'b1;
    ticks(2);
    start_btn = 1'b0;
    ticks(2);
    chk("lockout", {15'd0, running}, 16'h0001);
    ticks(594);
    chk("sec_10", sec, 16'h0010);
    pix("tens1", 10'd10, 10'd30, 1'b1, 6'h00);
    pix("hund_blank", 10'd10, 10'd24, 1'b1, 6'h3F);

    clear_btn = 1'b1;
    ticks(2);
    clear_btn = 1'b0;
    ticks(12);
    chk("clr_sec", sec, 16'h0000);
    chk("clr_run", {15'd0, running}, 16'h0000);

    start_btn = 1'b1;
    ticks(2);
    start_btn = 1'b0;
    ticks(121);
    start_btn = 1'b1;
    ticks(2);
    start_btn = 1'b0;
    ticks(200);
    chk("pause_sec", sec, 16'h0002);
    chk("pause_run", {15'd0, running}, 16'h0000);
    start_btn = 1'b1;
    ticks(2);
    start_btn = 1'b0;
    ticks(59);
    chk("resume_59", sec, 16'h0002);
    chk("resume_run", {15'd0, running}, 16'h0001);
    tick();
    chk("resume_60", sec, 16'h0003);

    start_btn = 1'b1;
    clear_btn = 1'b1;
    ticks(2);
    start_btn = 1'b0;
    clear_btn = 1'b0;
    tick();
    chk("both_sec", sec, 16'h0000);
    chk("both_run", {15'd0, running}, 16'h0000);

    start2 = 1'b1;
    ticks(2);
    start2 = 1'b0;
    ticks(10);
    chk("d2_carry", sec2, 16'h0010);
    ticks(9989);
    chk("d2_9999", sec2, 16'h9999);
    ticks(120);
    chk("d2_sat", sec2, 16'h9999);
    chk("d2_run", {15'd0, running2}, 16'h0001);
    clear2 = 1'b1;
    ticks(2);
    clear2 = 1'b0;
    tick();
    chk("d2_clr", sec2, 16'h0000);
    chk("d2_idle", {15'd0, running2}, 16'h0000);

    start_btn = 1'b1;
    ticks(2);
    start_btn = 1'b0;
    ticks(70);
    chk("pre_rst_sec", sec, 16'h0001);
    row = 10'd0;
    col = 10'd0;
    visible = 1'b0;
    hit = 4'b0100;
    @(posedge clk); #1;
    hit = 4'd0;
    pix("p2_flash", 10'd148, 10'd430, 1'b1, 6'h2B);
    rst = 1'b1;
    row = 10'd148;
    col = 10'd430;
    visible = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_rgb", {10'd0, rgb}, 16'h0000);
    chk("mid_rst_sec", sec, 16'h0000);
    chk("mid_rst_run", {15'd0, running}, 16'h0000);
    rst = 1'b0;
    pix("p2_top_idle", 10'd148, 10'd430, 1'b1, 6'h3F);
    pix("p2_idle", 10'd180, 10'd430, 1'b1, 6'h03);
    tick();
    pix("p2_no_pend", 10'd148, 10'd430, 1'b1, 6'h3F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
